poly_sound_sm: RTL and testbench
================================

// Module: poly_sound_sm
// PURPOSE
//  Parametrised polyphonic successor to the single-voice sound state machine.
//  Consumes PS/2 scan-code bytes (Enable strobe from the keyboard receiver) and decodes make, break (F0) and extended (E0) sequences.
//  Keeps up to VOICES simultaneously held notes; each voice outputs a tone half-period divisor for the tone generators downstream.
// PARAMETERS
//  VOICES   4   number of voice slots (1..8)
//  DIV_W    16  divisor width per voice (>=11)
// PORTS
//  Clock     in   1              system clock, rising edge
//  Reset     in   1              asynchronous, active-low reset
//  Keycode   in   8              scan-code byte, valid when Enable=1
//  Enable    in   1              one-cycle strobe: one byte consumed per cycle Enable=1
//  M         out  VOICES*DIV_W   voice i divisor at M[i*DIV_W +: DIV_W]; 0 = silent
//  Active    out  VOICES         voice i currently holding a key
//  Dropped   out  1              one-cycle pulse: new make had no free voice and was not stolen
// BEHAVIOUR
//  Reset (Reset=0, async): state=IDLE, all M=0, Active=0, Dropped=0, all voice key tags cleared.
//  Key map, divisors are 1 MHz tone-clock half-periods; all other codes are unmapped:
//    15->1911 (C4)  1D->1703 (D4)  24->1517 (E4)  2D->1432 (F4)
//    2C->1276 (G4)  35->1136 (A4)  3C->1012 (B4)  43->956 (C5)
//  Parser FSM, advances only on cycles with Enable=1:
//    IDLE:  F0->BRK; E0->EXT; 00 or FF->IDLE, no action; mapped code->MAKE action; unmapped->IDLE.
//    BRK:   any byte->IDLE; a mapped code performs the BREAK action.
//    EXT:   F0->EXT_BRK; any other byte->IDLE, no action.
//    EXT_BRK: any byte->IDLE, no action. Extended keys are never voiced.
//  MAKE action:
//    - Code already held in a voice (typematic repeat): no change.
//    - Otherwise allocate the lowest-index free voice: tag=code, M=divisor, Active=1.
//  BREAK action:
//    - Voice whose tag matches: M=0, Active=0, tag cleared.
//    - No match: no change, no error.
//  Latency: M/Active/Dropped update on the same rising edge that samples Enable=1, and are visible the following cycle.
//  Full: all voices Active and a new (unheld) mapped make arrives -> see VOICE_STEAL_EN.
//  Allocation and release are never simultaneous; only one byte is processed per cycle.
//  Enable held high N cycles = N identical bytes; the producer guarantees 1-cycle pulses.
//  Reset mid-sequence (e.g. after F0) returns to IDLE; the next mapped byte is treated as a make.
//  Widths: divisors are zero-extended to DIV_W. A table value that would exceed DIV_W is a synthesis-time error ($error in generate).
// CONFIGURATION
//  VOICE_STEAL_EN defined:
//    - Each voice carries an allocation age.
//    - A make while full replaces the oldest voice (tag and M overwritten in one cycle, Active stays 1).
//    - Dropped is never asserted.
//  VOICE_STEAL_EN undefined:
//    - A make while full is discarded; Dropped pulses for 1 cycle; voices are unchanged.
//    - No age logic is built.
// TESTING
//  1. Reset low for 3 cycles, then bytes 15, F0, 15 -> voice0 M=1911, Active=0001 after byte 1; after byte 3 M=0, Active=0000.
//  2. Bytes 15,1D,24,2D (VOICES=4) -> M = {1432,1517,1703,1911} for voice3..0; Active=1111; repeated byte 15 -> no change.
//  3. Full then byte 2C:
//     - without macro: Dropped pulses once, M unchanged;
//     - with VOICE_STEAL_EN: voice0 M=1276 (oldest stolen), Dropped stays 0.
//  4. Bytes E0,15 then E0,F0,15 -> no voice change; FSM ends in IDLE; a following 1D allocates M=1703.
//  5. Bytes 00, FF, 7E (unmapped), then F0,24 with E4 not held -> no output change at any point.
//  6. Byte F0, then Reset pulsed low mid-cycle (async), then byte 15 -> all M=0 immediately at reset; then voice0 M=1911 (make, not break).

Source files
------------

// File: rtl/poly_sound_sm_if.sv
// ---------------------------------------------------------------------------
// poly_sound_sm_if
//   Bundles the scan-code byte stream from the PS/2 receiver and the voice
//   outputs of poly_sound_sm.
//   master : byte producer / voice consumer (keyboard side, testbench)
//   slave  : poly_sound_sm
// Signals
//   Keycode  8              scan-code byte, valid when Enable=1
//   Enable   1              one byte consumed per cycle Enable=1
//   M        VOICES*DIV_W   voice i half-period divisor at M[i*DIV_W +: DIV_W]
//   Active   VOICES         voice i holding a key
//   Dropped  1              one-cycle pulse: make discarded, no free voice
// ---------------------------------------------------------------------------
interface poly_sound_sm_if #(
  parameter int VOICES = 4,
  parameter int DIV_W  = 16
);
  logic [7:0]              Keycode;
  logic                    Enable;
  logic [VOICES*DIV_W-1:0] M;
  logic [VOICES-1:0]       Active;
  logic                    Dropped;

  modport master (output Keycode, Enable, input M, Active, Dropped);
  modport slave  (input Keycode, Enable, output M, Active, Dropped);
endinterface

// File: rtl/poly_sound_sm.sv
// ---------------------------------------------------------------------------
// poly_sound_sm
//   Polyphonic PS/2 sound state machine. Decodes make, break (F0) and
//   extended (E0) scan-code sequences and keeps up to VOICES held notes, each
//   driving a 1 MHz tone-clock half-period divisor (0 = silent).
// Ports
//   Clock  in  system clock, rising edge
//   Reset  in  asynchronous, active-low reset
//   bus    slave modport of poly_sound_sm_if (Keycode/Enable in,
//          M/Active/Dropped out, all outputs registered)
// Configuration
//   VOICE_STEAL_EN : when defined, a make with all voices busy replaces the
//                    oldest voice; otherwise it is discarded and Dropped
//                    pulses for one cycle.
// ---------------------------------------------------------------------------
module poly_sound_sm #(
  parameter int VOICES = 4,
  parameter int DIV_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  poly_sound_sm_if.slave    bus
);

  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  // Widest table entry (1911) needs 11 bits.
  if (DIV_W < 11) begin : g_div_w_chk
    $error("poly_sound_sm: DIV_W=%0d cannot hold the divisor table", DIV_W);
  end
  if (VOICES < 1 || VOICES > 8) begin : g_voices_chk
    $error("poly_sound_sm: VOICES=%0d outside 1..8", VOICES);
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } state_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // Scan code -> tone half-period; 0 means the code is not a voiced key.
  function automatic logic [10:0] key_div(input logic [7:0] code);
    case (code)
      8'h15:   key_div = 11'd1911; // C4
      8'h1D:   key_div = 11'd1703; // D4
      8'h24:   key_div = 11'd1517; // E4
      8'h2D:   key_div = 11'd1432; // F4
      8'h2C:   key_div = 11'd1276; // G4
      8'h35:   key_div = 11'd1136; // A4
      8'h3C:   key_div = 11'd1012; // B4
      8'h43:   key_div = 11'd956;  // C5
      default: key_div = 11'd0;
    endcase
  endfunction

  state_t             state_q;
  logic [7:0]         tag_q    [VOICES];
  logic [DIV_W-1:0]   m_q      [VOICES];
  logic [VOICES-1:0]  active_q;
  logic               dropped_q;

  logic [DIV_W-1:0]   div_w;
  logic               mapped;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               make_req;
  logic               brk_req;
  logic               can_alloc;
  logic [IDX_W-1:0]   alloc_idx;

`ifdef VOICE_STEAL_EN
  // Age is the rank of a voice among the active voices: 0 = newest,
  // (active count - 1) = oldest. When full, ages are exactly 0..VOICES-1.
  logic [IDX_W-1:0]   age_q    [VOICES];
  logic [IDX_W-1:0]   oldest_idx;
`endif

  assign div_w  = DIV_W'(key_div(bus.Keycode));
  assign mapped = (div_w != '0);

  // NOTE: every variable written here gets a default first, so no path can
  // leave it holding a stale value and infer a latch.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (!hit && active_q[i] && (tag_q[i] == bus.Keycode)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    // Scan downwards so the lowest free index wins.
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  always_comb begin
    oldest_idx = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (active_q[i] && (age_q[i] == IDX_W'(VOICES - 1))) oldest_idx = IDX_W'(i);
    end
  end
  assign can_alloc = 1'b1;
  assign alloc_idx = free_found ? free_idx : oldest_idx;
`else
  assign can_alloc = free_found;
  assign alloc_idx = free_idx;
`endif

  // A held code (typematic repeat) never reallocates.
  assign make_req = bus.Enable && (state_q == S_IDLE) && mapped && !hit;
  assign brk_req  = bus.Enable && (state_q == S_BRK) && hit;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      active_q  <= '0;
      dropped_q <= 1'b0;
      // NOTE: the per-voice arrays are reset explicitly; a stale tag would
      // otherwise match a break or block a make after reset.
      for (int i = 0; i < VOICES; i++) begin
        tag_q[i] <= '0;
        m_q[i]   <= '0;
`ifdef VOICE_STEAL_EN
        age_q[i] <= '0;
`endif
      end
    end else begin
      // Parser: only advances on bytes.
      if (bus.Enable) begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.Keycode == BREAK_CODE)    state_q <= S_BRK;
            else if (bus.Keycode == EXT_CODE) state_q <= S_EXT;
          end
          S_BRK:     state_q <= S_IDLE;
          S_EXT:     state_q <= (bus.Keycode == BREAK_CODE) ? S_EXT_BRK : S_IDLE;
          S_EXT_BRK: state_q <= S_IDLE;
        endcase
      end

      dropped_q <= make_req && !can_alloc;

      // Allocation and release are mutually exclusive by parser state.
      if (make_req && can_alloc) begin
        tag_q[alloc_idx]    <= bus.Keycode;
        m_q[alloc_idx]      <= div_w;
        active_q[alloc_idx] <= 1'b1;
`ifdef VOICE_STEAL_EN
        // The stolen voice, if any, is the oldest, so every other active
        // voice ages by one without leaving 0..VOICES-1.
        age_q[alloc_idx] <= '0;
        for (int i = 0; i < VOICES; i++) begin
          if (active_q[i] && (IDX_W'(i) != alloc_idx)) age_q[i] <= age_q[i] + IDX_W'(1);
        end
`endif
      end else if (brk_req) begin
        tag_q[hit_idx]    <= '0;
        m_q[hit_idx]      <= '0;
        active_q[hit_idx] <= 1'b0;
`ifdef VOICE_STEAL_EN
        // Close the gap in the ranking left by the released voice.
        age_q[hit_idx] <= '0;
        for (int i = 0; i < VOICES; i++) begin
          if (active_q[i] && (age_q[i] > age_q[hit_idx])) age_q[i] <= age_q[i] - IDX_W'(1);
        end
`endif
      end
    end
  end

  always_comb begin
    bus.M = '0;
    for (int i = 0; i < VOICES; i++) bus.M[i*DIV_W +: DIV_W] = m_q[i];
  end
  assign bus.Active  = active_q;
  assign bus.Dropped = dropped_q;

endmodule

// File: tb/tb_poly_sound_sm.sv
// ---------------------------------------------------------------------------
// tb_poly_sound_sm
//   Self-checking bench for poly_sound_sm (VOICES=4, DIV_W=16). A behavioural
//   model tracks held notes per slot and an allocation-order queue; directed
//   scenarios and a randomized byte stream are compared against it.
// ---------------------------------------------------------------------------
module tb_poly_sound_sm;

  localparam int VOICES = 4;
  localparam int DIV_W  = 16;
  localparam int VW     = VOICES * DIV_W;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  poly_sound_sm_if #(.VOICES(VOICES), .DIV_W(DIV_W)) bus ();

  poly_sound_sm #(.VOICES(VOICES), .DIV_W(DIV_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // ---------------- reference model ----------------
  int mtag  [VOICES];   // 0 = slot free
  int mdiv  [VOICES];
  int order [$];        // slot indices, oldest allocation first
  int pstate;           // 0 idle, 1 after F0, 2 after E0, 3 after E0 F0
  bit mdrop;

  function automatic int note_div(input int code);
    case (code)
      'h15: return 1911;
      'h1D: return 1703;
      'h24: return 1517;
      'h2D: return 1432;
      'h2C: return 1276;
      'h35: return 1136;
      'h3C: return 1012;
      'h43: return 956;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    foreach (mtag[i]) begin mtag[i] = 0; mdiv[i] = 0; end
    order.delete();
    pstate = 0;
    mdrop  = 1'b0;
  endfunction

  function automatic void model_make(input int b);
    int free_v;
    int v;
    free_v = -1;
    foreach (mtag[i]) if (mtag[i] == b) return;
    for (int i = VOICES - 1; i >= 0; i--) if (mtag[i] == 0) free_v = i;
    if (free_v >= 0) begin
      mtag[free_v] = b; mdiv[free_v] = note_div(b); order.push_back(free_v);
    end else begin
`ifdef VOICE_STEAL_EN
      v = order.pop_front();
      mtag[v] = b; mdiv[v] = note_div(b); order.push_back(v);
`else
      v = 0;
      mdrop = 1'b1;
`endif
    end
  endfunction

  function automatic void model_break(input int b);
    foreach (mtag[i]) begin
      if (mtag[i] == b) begin
        mtag[i] = 0; mdiv[i] = 0;
        for (int j = 0; j < order.size(); j++) if (order[j] == i) begin order.delete(j); break; end
        return;
      end
    end
  endfunction

  function automatic void model_byte(input int b);
    mdrop = 1'b0;
    case (pstate)
      0: if (b == 'hF0) pstate = 1;
         else if (b == 'hE0) pstate = 2;
         else if (note_div(b) != 0) model_make(b);
      1: begin pstate = 0; if (note_div(b) != 0) model_break(b); end
      2: pstate = (b == 'hF0) ? 3 : 0;
      default: pstate = 0;
    endcase
  endfunction

  function automatic logic [VW-1:0] exp_m();
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < VOICES; i++) r[i*DIV_W +: DIV_W] = DIV_W'(mdiv[i]);
    return r;
  endfunction

  function automatic logic [VOICES-1:0] exp_active();
    logic [VOICES-1:0] r;
    r = '0;
    for (int i = 0; i < VOICES; i++) r[i] = (mtag[i] != 0);
    return r;
  endfunction

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge Clock);
    bus.Keycode = b;
    bus.Enable  = 1'b1;
    model_byte(int'(b));
    @(negedge Clock);
    bus.Enable  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge Clock);
    mdrop = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.Keycode = 8'h00;
    bus.Enable  = 1'b0;
    Reset       = 1'b0;
    model_reset();
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checks++;
    if ({bus.M, bus.Active, bus.Dropped} !== {VW'(0), VOICES'(0), 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got M=%h Active=%b Dropped=%b, want all zero", bus.M, bus.Active, bus.Dropped);
    end
    Reset = 1'b1;
  endtask

  task automatic test_make_break();
    logic [7:0] seq [3] = '{8'h15, 8'hF0, 8'h15};
    apply_reset();
    foreach (seq[k]) begin
      send_byte(seq[k]);
      checks++;
      if ({bus.M, bus.Active, bus.Dropped} !== {exp_m(), exp_active(), mdrop}) begin
        errors++;
        $display("FAIL make_break byte%0d: got M=%h A=%b D=%b, want M=%h A=%b D=%b",
                 k, bus.M, bus.Active, bus.Dropped, exp_m(), exp_active(), mdrop);
      end
      if (k == 0) begin
        checks++;
        if ({bus.M[DIV_W-1:0], bus.Active} !== {16'd1911, 4'b0001}) begin
          errors++;
          $display("FAIL make_c4: got M0=%0d A=%b, want 1911 0001", bus.M[DIV_W-1:0], bus.Active);
        end
      end
    end
    checks++;
    if ({bus.M, bus.Active} !== {VW'(0), 4'b0000}) begin
      errors++;
      $display("FAIL break_c4: got M=%h A=%b, want 0 0000", bus.M, bus.Active);
    end
  endtask

  task automatic test_fill_and_full();
    logic [7:0] seq [4] = '{8'h15, 8'h1D, 8'h24, 8'h2D};
    apply_reset();
    foreach (seq[k]) begin
      send_byte(seq[k]);
      checks++;
      if ({bus.M, bus.Active, bus.Dropped} !== {exp_m(), exp_active(), mdrop}) begin
        errors++;
        $display("FAIL fill byte%0d: got M=%h A=%b, want M=%h A=%b", k, bus.M, bus.Active, exp_m(), exp_active());
      end
    end
    checks++;
    if ({bus.M, bus.Active} !== {16'd1432, 16'd1517, 16'd1703, 16'd1911, 4'b1111}) begin
      errors++;
      $display("FAIL fill_all: got M=%h A=%b, want 059805ed06a70777 1111", bus.M, bus.Active);
    end
    send_byte(8'h15);   // typematic repeat
    checks++;
    if ({bus.M, bus.Active, bus.Dropped} !== {16'd1432, 16'd1517, 16'd1703, 16'd1911, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL repeat_make: got M=%h A=%b D=%b, want unchanged, D=0", bus.M, bus.Active, bus.Dropped);
    end
    send_byte(8'h2C);   // make with all voices held
`ifdef VOICE_STEAL_EN
    checks++;
    if ({bus.M, bus.Active, bus.Dropped} !== {16'd1432, 16'd1517, 16'd1703, 16'd1276, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL steal_oldest: got M=%h A=%b D=%b, want voice0=1276 D=0", bus.M, bus.Active, bus.Dropped);
    end
`else
    checks++;
    if ({bus.M, bus.Active, bus.Dropped} !== {16'd1432, 16'd1517, 16'd1703, 16'd1911, 4'b1111, 1'b1}) begin
      errors++;
      $display("FAIL full_drop: got M=%h A=%b D=%b, want unchanged, D=1", bus.M, bus.Active, bus.Dropped);
    end
`endif
    idle_cycle();
    checks++;
    if ({bus.M, bus.Active, bus.Dropped} !== {exp_m(), exp_active(), 1'b0}) begin
      errors++;
      $display("FAIL drop_one_cycle: got M=%h A=%b D=%b, want M=%h A=%b D=0",
               bus.M, bus.Active, bus.Dropped, exp_m(), exp_active());
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq [5] = '{8'hE0, 8'h15, 8'hE0, 8'hF0, 8'h15};
    apply_reset();
    foreach (seq[k]) begin
      send_byte(seq[k]);
      checks++;
      if ({bus.M, bus.Active, bus.Dropped} !== {VW'(0), VOICES'(0), 1'b0}) begin
        errors++;
        $display("FAIL extended byte%0d: got M=%h A=%b D=%b, want no voice", k, bus.M, bus.Active, bus.Dropped);
      end
    end
    send_byte(8'h1D);
    checks++;
    if ({bus.M, bus.Active} !== {48'd0, 16'd1703, 4'b0001}) begin
      errors++;
      $display("FAIL ext_then_make: got M=%h A=%b, want voice0=1703 A=0001", bus.M, bus.Active);
    end
  endtask

  task automatic test_ignored();
    logic [7:0] seq [5] = '{8'h00, 8'hFF, 8'h7E, 8'hF0, 8'h24};
    apply_reset();
    send_byte(8'h15);
    foreach (seq[k]) begin
      send_byte(seq[k]);
      checks++;
      if ({bus.M, bus.Active, bus.Dropped} !== {48'd0, 16'd1911, 4'b0001, 1'b0}) begin
        errors++;
        $display("FAIL ignored byte%0d: got M=%h A=%b D=%b, want voice0=1911 only", k, bus.M, bus.Active, bus.Dropped);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_byte(8'h15);
    send_byte(8'h1D);
    send_byte(8'hF0);
    #2;                 // between edges
    Reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.M, bus.Active, bus.Dropped} !== {VW'(0), VOICES'(0), 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got M=%h A=%b D=%b, want all zero", bus.M, bus.Active, bus.Dropped);
    end
    @(negedge Clock);
    Reset = 1'b1;
    send_byte(8'h15);
    checks++;
    if ({bus.M, bus.Active} !== {48'd0, 16'd1911, 4'b0001}) begin
      errors++;
      $display("FAIL make_after_reset: got M=%h A=%b, want voice0=1911 A=0001", bus.M, bus.Active);
    end
  endtask

  task automatic test_random();
    int keys [8] = '{'h15, 'h1D, 'h24, 'h2D, 'h2C, 'h35, 'h3C, 'h43};
    int sel;
    logic [7:0] b;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 55)      b = 8'(keys[$urandom_range(0, 7)]);
      else if (sel < 75) b = 8'hF0;
      else if (sel < 83) b = 8'hE0;
      else if (sel < 88) b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      else               b = 8'($urandom_range(0, 255));
      send_byte(b);
      checks++;
      if ({bus.M, bus.Active, bus.Dropped} !== {exp_m(), exp_active(), mdrop}) begin
        errors++;
        $display("FAIL random n=%0d byte=%h: got M=%h A=%b D=%b, want M=%h A=%b D=%b",
                 n, b, bus.M, bus.Active, bus.Dropped, exp_m(), exp_active(), mdrop);
      end
      if ($urandom_range(0, 7) == 0) idle_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_fill_and_full();
    test_extended();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
